instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 130 +++++++++++++
 tb/tb_instr_fetch.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : Single-issue instruction fetch with one-entry hold buffer and
//             redirect drain of in-flight memory reads.
//  Revision : 1.0  initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_stall_in_dq,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_stall_out_dq
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;
    logic        r_valid;
    logic        r_req;

    logic        w_ack;
    logic        w_out_free;
    logic        w_handoff;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_inc;

    // An ack is only meaningful while a request is actually outstanding.
    assign w_ack         = r_req & i_imem_ack;
    assign w_handoff     = r_valid & ~i_stall_in_dq;
    assign w_out_free    = ~r_valid | ~i_stall_in_dq;
    assign w_redirect_pc = i_redirect_pc & ~32'd3;
    assign w_pc_inc      = r_pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_target     <= RESET_PC;
            r_instr      <= 32'd0;
            r_instr_pc   <= 32'd0;
            r_hold_instr <= 32'd0;
            r_hold_pc    <= 32'd0;
            r_valid      <= 1'b0;
            r_req        <= 1'b0;
        end else begin
            r_req <= 1'b1;
            case (r_state)
                S_FETCH: begin
                    if (i_redirect) begin
                        r_valid <= 1'b0;
                        if (w_ack || !r_req) begin
                            r_pc <= w_redirect_pc;
                        end else begin
                            // The old read must complete before the new address goes out.
                            r_target <= w_redirect_pc;
                            r_state  <= S_DRAIN;
                        end
                    end else if (w_ack && w_out_free) begin
                        r_instr    <= i_imem_data;
                        r_instr_pc <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= w_pc_inc;
                    end else if (w_ack) begin
                        r_hold_instr <= i_imem_data;
                        r_hold_pc    <= r_pc;
                        r_pc         <= w_pc_inc;
                        r_req        <= 1'b0;
                        r_state      <= S_HOLD;
                    end else if (w_handoff) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (i_redirect) begin
                        r_valid <= 1'b0;
                        r_pc    <= w_redirect_pc;
                        r_state <= S_FETCH;
                    end else if (!i_stall_in_dq) begin
                        r_instr    <= r_hold_instr;
                        r_instr_pc <= r_hold_pc;
                        r_valid    <= 1'b1;
                        r_state    <= S_FETCH;
                    end else begin
                        r_req <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (w_ack) begin
                        r_pc    <= i_redirect ? w_redirect_pc : r_target;
                        r_state <= S_FETCH;
                    end else if (i_redirect) begin
                        r_target <= w_redirect_pc;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign o_imem_req     = r_req;
    assign o_imem_addr    = r_pc;
    assign o_instr        = r_instr;
    assign o_instr_pc     = r_instr_pc;
    assign o_stall_out_dq = ~r_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Directed plus randomized bench for instr_fetch against a
//             delivery-order reference model and a variable-latency memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_stall_in_dq = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'd0;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack = 1'b0;
    logic [31:0] i_imem_data = 32'd0;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        o_stall_out_dq;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(C_RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_stall_in_dq  (i_stall_in_dq),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_imem_req     (o_imem_req),
        .o_imem_addr    (o_imem_addr),
        .i_imem_ack     (i_imem_ack),
        .i_imem_data    (i_imem_data),
        .o_instr        (o_instr),
        .o_instr_pc     (o_instr_pc),
        .o_stall_out_dq (o_stall_out_dq)
    );

    int          total = 0;
    int          bad = 0;
    int          n_deliv = 0;
    logic [31:0] exp_pc = C_RESET_PC;
    logic        exp_flush = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'd0;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One cycle: at the falling edge, check, respond as memory, drive inputs,
    // and predict what DQ takes at the next rising edge.
    task automatic step(input logic stall, input logic redir, input logic [31:0] rpc, input int lat);
        @(negedge clk);
        if (exp_flush) check("stall_after_flush", {31'd0, o_stall_out_dq}, 32'd1);
        if (o_imem_req) begin
            check("addr_align", {30'd0, o_imem_addr[1:0]}, 32'd0);
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = o_imem_addr;
                mem_cnt  = lat;
            end else begin
                check("addr_stable", o_imem_addr, mem_addr);
            end
            if (mem_cnt == 0) begin
                i_imem_ack  = 1'b1;
                i_imem_data = mem_word(mem_addr);
                mem_busy    = 1'b0;
            end else begin
                i_imem_ack  = 1'b0;
                i_imem_data = $urandom;
                mem_cnt--;
            end
        end else begin
            if (mem_busy) check("req_held", {31'd0, o_imem_req}, 32'd1);
            mem_busy    = 1'b0;
            i_imem_ack  = 1'b0;
            i_imem_data = $urandom;
        end
        i_stall_in_dq = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        exp_flush     = redir;
        if (redir) begin
            exp_pc = rpc & ~32'd3;
        end else if (!o_stall_out_dq && !stall) begin
            check("deliver_pc", o_instr_pc, exp_pc);
            check("deliver_instr", o_instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
    endtask

    task automatic do_reset(input logic pending_ack);
        @(negedge clk);
        i_imem_ack  = pending_ack;
        i_imem_data = 32'hDEAD_BEEF;
        rst_n       = 1'b0;
        #1;
        check("rst_req", {31'd0, o_imem_req}, 32'd0);
        check("rst_stall_out", {31'd0, o_stall_out_dq}, 32'd1);
        check("rst_instr", o_instr, 32'd0);
        check("rst_instr_pc", o_instr_pc, 32'd0);
        @(negedge clk);
        rst_n         = 1'b1;
        i_imem_ack    = 1'b0;
        i_stall_in_dq = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = 32'd0;
        mem_busy      = 1'b0;
        exp_pc        = C_RESET_PC;
        exp_flush     = 1'b1;
    endtask

    initial begin
        logic        stall;
        logic        redir;
        logic [31:0] rpc;

        // Zero-latency streaming after reset.
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s1_addr0", o_imem_addr, 32'h100);
        check("s1_stall_before_ack", {31'd0, o_stall_out_dq}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 32'd0, 0);
            check("s1_addr", o_imem_addr, 32'h104 + 32'(4 * k));
            check("s1_out_pc", o_instr_pc, 32'h100 + 32'(4 * k));
            check("s1_out_valid", {31'd0, o_stall_out_dq}, 32'd0);
        end

        // Back-pressure for five cycles fills the hold buffer.
        do_reset(1'b0);
        step(1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 32'd0, 0);
        step(1'b1, 1'b0, 32'd0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b0, 32'd0, 0);
            check("s2_req_low", {31'd0, o_imem_req}, 32'd0);
            check("s2_out_hold", o_instr_pc, 32'h104);
        end
        step(1'b0, 1'b0, 32'd0, 0);
        check("s2_release_first", o_instr_pc, 32'h104);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s2_release_second", o_instr_pc, 32'h108);
        check("s2_next_addr", o_imem_addr, 32'h10C);

        // Redirect while a slow read is in flight.
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'd0, 0);
        step(1'b0, 1'b0, 32'd0, 3);
        step(1'b0, 1'b1, 32'h200, 0);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s3_drain_addr", o_imem_addr, 32'h10C);
        check("s3_drain_req", {31'd0, o_imem_req}, 32'd1);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s3_drain_addr_ack", o_imem_addr, 32'h10C);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s3_target_addr", o_imem_addr, 32'h200);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s3_target_out", o_instr_pc, 32'h200);

        // Redirect coincident with ack, unaligned target and PC wrap.
        step(1'b0, 1'b1, 32'h0000_0003, 0);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s4_aligned_addr", o_imem_addr, 32'h0);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s4_out_zero", o_instr_pc, 32'h0);
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 0);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s4_wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s4_wrap_addr1", o_imem_addr, 32'h0);
        check("s4_wrap_out0", o_instr_pc, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s4_wrap_out1", o_instr_pc, 32'h0);

        // Reset mid-stream with an ack pending.
        step(1'b0, 1'b0, 32'd0, 2);
        do_reset(1'b1);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s5_restart_addr", o_imem_addr, C_RESET_PC);
        step(1'b0, 1'b0, 32'd0, 0);
        check("s5_restart_out", o_instr_pc, C_RESET_PC);

        // Randomized traffic against the delivery-order model.
        n_deliv = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset(1'($urandom_range(0, 1)));
            stall = ($urandom_range(0, 99) < 30);
            redir = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else rpc = $urandom;
            step(stall, redir, rpc, $urandom_range(0, 3));
        end
        check("random_progress", {31'd0, (n_deliv > 300)}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
